line_fill_sequencer: RTL and testbench
======================================

# line_fill_sequencer

Converts one cache-line fill request into a sequence of single-word reads through the word-wide bus read master, and assembles the returned words into a full line. Sits directly upstream of the read master, between the cache miss logic and the bus: it drives the read master's request channel and consumes its data-return channel. It fetches the requested word first and wraps around within the line. It forwards that critical word early so the consumer can restart before the line completes.

## Interface
Parameters
- `LINE_WORDS`, 4: 32-bit words per line; must be a power of two ≥ 2.
- `OFF_BITS`, 2: log2(`LINE_WORDS`); word-index width.

Ports
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces the reset state immediately.
- `fill_valid`  in  1  miss logic presents a fill request.
- `fill_ready`  out  1  sequencer can accept a request (IDLE only).
- `fill_address`  in  32  byte address of the missing word; bits [1:0] ignored.
- `line_valid`  out  1  assembled line available.
- `line_ready`  in  1  consumer takes the line.
- `line_address`  out  32  line-aligned base address of the returned line.
- `line_data`  out  32*LINE_WORDS  word i in bits [32i+31:32i], indexed by address, not by fetch order.
- `crit_valid`  out  1  one-cycle pulse when the critical (first) word returns.
- `crit_data`  out  32  critical word; valid only with `crit_valid`.
- `req_valid`  out  1  word read request to the read master.
- `req_ready`  in  1  read master accepts the request.
- `req_address`  out  32  word-aligned address of the word read.
- `dp_valid`  in  1  read master returns a data word.
- `dp_ready`  out  1  sequencer accepts the data word.
- `dp_read_data`  in  32  returned word.

## Operation
- States: IDLE, REQ, RESP, DONE. Registers: `base` (line address), `idx` (OFF_BITS), `cnt` (OFF_BITS+1), `first`, and the line buffer.
- IDLE: `fill_ready`=1. On `fill_valid`:
  - `base` ← `fill_address` with the low OFF_BITS+2 bits cleared.
  - `idx` ← `fill_address`[OFF_BITS+1:2].
  - `cnt` ← 0, `first` ← 1, then go to REQ.
- REQ: `req_valid`=1, `req_address` = `base` | (`idx` << 2). On `req_valid & req_ready`, go to RESP.
- RESP: `dp_ready`=1. On `dp_valid`:
  - Write `dp_read_data` into word slot `idx`.
  - If `first`, pulse `crit_valid` with `crit_data` = `dp_read_data`; then `first` ← 0.
  - `idx` ← `idx`+1 mod `LINE_WORDS` (wrap), `cnt` ← `cnt`+1.
  - If `cnt` was `LINE_WORDS`-1, go to DONE; otherwise go to REQ.
- DONE: `line_valid`=1, `line_address`=`base`. On `line_ready`, go to IDLE.
- Exactly one read is outstanding at a time. `req_valid` and `dp_ready` are never high together.
- `req_valid`, `fill_ready`, `dp_ready` and `line_valid` are Moore decodes of state. `crit_valid`/`crit_data` are registered.
- `line_data` and `line_address` hold stable from DONE until the next fill is accepted. Buffer slots not yet written during a fill retain stale contents; only DONE guarantees the whole line.
- `dp_valid` outside RESP is ignored. `fill_valid` outside IDLE is ignored.
- Reset values: state IDLE, so `fill_ready`=1 and `req_valid`, `dp_ready`, `line_valid`, `crit_valid` are 0. `line_data`, `line_address`, `crit_data`, `req_address`, `idx` and `cnt` are all 0.
- Reset mid-fill abandons the fill. If a read master request is in flight, the read master shares the same reset, so nothing is left dangling.

## Timing
- Fill accepted in cycle T: `req_valid` is high from T+1.
- With `req_ready` and `dp_valid` each high on first assertion, every word costs 2 cycles. Words complete at T+2, T+4, T+6, T+8; `line_valid` is high at T+9.
- `crit_valid` is high in the cycle after the first `dp_valid` handshake (T+3 minimum).
- `req_address` stays stable while `req_valid` is held without `req_ready`.
- Back-to-back: `line_ready` at cycle D returns to IDLE at D+1, so `fill_ready` is high at D+1. There is no bypass from DONE to REQ.

## Structure
- Shared defines include: the state encodings (IDLE=2'b00, REQ=2'b01, RESP=2'b10, DONE=2'b11), the word-size constant (4 bytes), and the default `LINE_WORDS`.
- One sub-module, `line_word_buffer`: `LINE_WORDS` 32-bit registers, each with a write enable from a decoded `idx`, async-reset to 0. It presents the concatenated `line_data`.
- The FSM and the `idx`/`cnt` counters live in the top module.

## Test plan
- Aligned fill: memory model returns data = address. `fill_address`=0x0000_1000.
  - Requests go to 0x1000, 0x1004, 0x1008, 0x100C.
  - `line_data`={0x100C,0x1008,0x1004,0x1000}, `line_address`=0x1000, `line_valid` at T+9.
- Critical-word wrap: `fill_address`=0x0000_100A.
  - Request order 0x1008, 0x100C, 0x1000, 0x1004.
  - Single `crit_valid` with `crit_data`=0x1008.
  - `line_data` identical to the aligned case.
- Backpressure: `req_ready` low 3 cycles on every request, `dp_valid` 5 cycles late.
  - `req_address` is stable while waiting, exactly 4 requests are issued, and `dp_ready`/`req_valid` are never both high.
- Line stall: `line_ready` low 4 cycles in DONE, with `fill_valid` held high.
  - `line_valid`, `line_data` and `line_address` stay constant and `fill_ready` stays 0.
  - The new fill is accepted the cycle after `line_ready`.
- Reset after the 2nd word returns: every output takes its reset value asynchronously, with no further `req_valid`.
  - A subsequent fill of 0x2004 completes with the correct line.
- Stray `dp_valid` asserted in IDLE and REQ: no buffer write, `idx`/`cnt` unchanged.

Source files
------------

// File: rtl/line_fill_sequencer_pkg.sv
// rtl/line_fill_sequencer_pkg.sv - shared states and constants for the line fill sequencer
package line_fill_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10,
        ST_DONE = 2'b11
    } fill_state_t;

    localparam int WORD_BYTES         = 4;
    localparam int DEFAULT_LINE_WORDS = 4;

endpackage

// File: rtl/line_word_buffer.sv
// rtl/line_word_buffer.sv - per-word line buffer, written by word index, read as a whole line
module line_word_buffer #(
    parameter int LINE_WORDS = 4,
    parameter int OFF_BITS   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [OFF_BITS-1:0]        wr_idx,
    input  logic [31:0]                wr_data,
    output logic [32*LINE_WORDS-1:0]   line_data
);

    logic [31:0] words [LINE_WORDS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                words[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                if (wr_en && (wr_idx == OFF_BITS'(i))) begin
                    words[i] <= wr_data;
                end
            end
        end
    end

    // slots are laid out by address offset, not by fetch order
    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_pack
        assign line_data[32*g +: 32] = words[g];
    end

endmodule

// File: rtl/line_fill_sequencer.sv
// rtl/line_fill_sequencer.sv - critical-word-first line fill via single-word bus reads
module line_fill_sequencer
    import line_fill_sequencer_pkg::*;
#(
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
    parameter int OFF_BITS   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fill_valid,
    output logic                       fill_ready,
    input  logic [31:0]                fill_address,
    output logic                       line_valid,
    input  logic                       line_ready,
    output logic [31:0]                line_address,
    output logic [32*LINE_WORDS-1:0]   line_data,
    output logic                       crit_valid,
    output logic [31:0]                crit_data,
    output logic                       req_valid,
    input  logic                       req_ready,
    output logic [31:0]                req_address,
    input  logic                       dp_valid,
    output logic                       dp_ready,
    input  logic [31:0]                dp_read_data
);

    localparam int BYTE_BITS = $clog2(WORD_BYTES);
    localparam int LINE_BITS = OFF_BITS + BYTE_BITS;

    fill_state_t          state, next_state;
    logic [31:0]          base;
    logic [OFF_BITS-1:0]  idx;
    logic [OFF_BITS:0]    cnt;
    logic                 first;
    logic                 fill_fire;
    logic                 dp_fire;
    logic                 last_word;
    logic                 unused_byte_bits;

    assign unused_byte_bits = ^fill_address[BYTE_BITS-1:0];

    assign fill_fire    = (state == ST_IDLE) && fill_valid;
    assign dp_fire      = (state == ST_RESP) && dp_valid;
    assign last_word    = (cnt == (OFF_BITS+1)'(LINE_WORDS - 1));
    assign req_address  = base | (32'(idx) << BYTE_BITS);
    assign line_address = base;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        fill_ready = 1'b0;
        req_valid  = 1'b0;
        dp_ready   = 1'b0;
        line_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                fill_ready = 1'b1;
                if (fill_valid) next_state = ST_REQ;
            end
            ST_REQ: begin
                req_valid = 1'b1;
                if (req_ready) next_state = ST_RESP;
            end
            ST_RESP: begin
                dp_ready = 1'b1;
                if (dp_valid) next_state = last_word ? ST_DONE : ST_REQ;
            end
            ST_DONE: begin
                line_valid = 1'b1;
                if (line_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // idx wraps within the line so the fetch starts at the missing word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base       <= '0;
            idx        <= '0;
            cnt        <= '0;
            first      <= 1'b0;
            crit_valid <= 1'b0;
            crit_data  <= '0;
        end else begin
            crit_valid <= 1'b0;
            if (fill_fire) begin
                base  <= {fill_address[31:LINE_BITS], LINE_BITS'(0)};
                idx   <= fill_address[LINE_BITS-1:BYTE_BITS];
                cnt   <= '0;
                first <= 1'b1;
            end else if (dp_fire) begin
                idx   <= idx + 1'b1;
                cnt   <= cnt + 1'b1;
                first <= 1'b0;
                if (first) begin
                    crit_valid <= 1'b1;
                    crit_data  <= dp_read_data;
                end
            end
        end
    end

    line_word_buffer #(
        .LINE_WORDS (LINE_WORDS),
        .OFF_BITS   (OFF_BITS)
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (dp_fire),
        .wr_idx    (idx),
        .wr_data   (dp_read_data),
        .line_data (line_data)
    );

endmodule

// File: tb/tb_line_fill_sequencer.sv
// tb/tb_line_fill_sequencer.sv - randomized self-checking bench for line_fill_sequencer
module tb_line_fill_sequencer;

    localparam int LW = 4;
    localparam int OB = 2;
    localparam int CW = 32 * LW;

    logic          clk = 1'b0;
    logic          reset;
    logic          fill_valid;
    logic          fill_ready;
    logic [31:0]   fill_address;
    logic          line_valid;
    logic          line_ready;
    logic [31:0]   line_address;
    logic [CW-1:0] line_data;
    logic          crit_valid;
    logic [31:0]   crit_data;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_address;
    logic          dp_valid;
    logic          dp_ready;
    logic [31:0]   dp_read_data;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] key    = '0;

    always #5 clk = ~clk;

    line_fill_sequencer #(.LINE_WORDS(LW), .OFF_BITS(OB)) dut (
        .clk          (clk),
        .reset        (reset),
        .fill_valid   (fill_valid),
        .fill_ready   (fill_ready),
        .fill_address (fill_address),
        .line_valid   (line_valid),
        .line_ready   (line_ready),
        .line_address (line_address),
        .line_data    (line_data),
        .crit_valid   (crit_valid),
        .crit_data    (crit_data),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_address  (req_address),
        .dp_valid     (dp_valid),
        .dp_ready     (dp_ready),
        .dp_read_data (dp_read_data)
    );

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ key;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fill_ready"}, fill_ready, 1);
        check({tag, "_req_valid"}, req_valid, 0);
        check({tag, "_dp_ready"}, dp_ready, 0);
        check({tag, "_line_valid"}, line_valid, 0);
        check({tag, "_crit_valid"}, crit_valid, 0);
        check({tag, "_line_data"}, line_data, 0);
        check({tag, "_line_address"}, line_address, 0);
        check({tag, "_crit_data"}, crit_data, 0);
        check({tag, "_req_address"}, req_address, 0);
    endtask

    // One fill with a responder model; abort_after>0 returns right after that many data words.
    task automatic run_fill(input logic [31:0] addr, input int rstall, input int dstall,
                            input int lstall, input bit stray, input int abort_after,
                            input bit hold_fill);
        logic [31:0]   base;
        logic [31:0]   exp_req[$];
        logic [CW-1:0] exp_line;
        logic [31:0]   hold_addr, last_addr;
        int            n, nreq, ndp, ncrit, wr, wd;
        bit            new_req, new_dp, got_line;
        base = addr & ~32'(4 * LW - 1);
        for (int k = 0; k < LW; k++)
            exp_req.push_back(base + 32'(((int'(addr[OB+1:2]) + k) % LW) * 4));
        for (int i = 0; i < LW; i++)
            exp_line[32*i +: 32] = mem(base + 32'(4 * i));
        n = 0;
        while (!fill_ready && n < 50) begin
            step();
            n++;
        end
        check("fill_ready_wait", fill_ready, 1);
        fill_valid   = 1'b1;
        fill_address = addr;
        step();
        if (!hold_fill) fill_valid = 1'b0;
        n = 1; nreq = 0; ndp = 0; ncrit = 0; wr = 0; wd = 0;
        new_req = 1; new_dp = 1; got_line = 0; hold_addr = '0; last_addr = '0;
        while (!got_line && n < 400) begin
            req_ready    = 1'b0;
            dp_valid     = 1'b0;
            dp_read_data = 32'hDEAD_BEEF;
            check("no_overlap", req_valid & dp_ready, 0);
            if (crit_valid) begin
                ncrit++;
                check("crit_data", crit_data, mem(addr & ~32'h3));
                if (rstall == 0 && dstall == 0) check("crit_time", n, 3);
            end
            if (line_valid) begin
                got_line = 1;
                if (rstall == 0 && dstall == 0) check("line_time", n, 9);
            end else begin
                if (req_valid) begin
                    if (new_req) begin
                        new_req   = 0;
                        wr        = rstall;
                        hold_addr = req_address;
                        if (nreq < LW) check("req_addr", req_address, exp_req[nreq]);
                        else check("extra_req", 1, 0);
                    end else begin
                        check("req_addr_hold", req_address, hold_addr);
                    end
                    if (wr == 0) begin
                        req_ready = 1'b1;
                        new_req   = 1;
                        last_addr = req_address;
                        nreq++;
                    end else begin
                        wr--;
                        if (stray) dp_valid = 1'b1;
                    end
                end
                if (dp_ready) begin
                    if (new_dp) begin
                        new_dp = 0;
                        wd     = dstall;
                    end
                    if (wd == 0) begin
                        dp_valid     = 1'b1;
                        dp_read_data = mem(last_addr);
                        new_dp       = 1;
                        ndp++;
                    end else begin
                        wd--;
                    end
                end
                step();
                n++;
                req_ready = 1'b0;
                dp_valid  = 1'b0;
                if (abort_after != 0 && ndp == abort_after) return;
            end
        end
        check("line_seen", got_line, 1);
        check("req_count", nreq, LW);
        check("dp_count", ndp, LW);
        check("crit_count", ncrit, 1);
        check("line_data", line_data, exp_line);
        check("line_address", line_address, base);
        for (int s = 0; s < lstall; s++) begin
            line_ready = 1'b0;
            step();
            check("stall_line_valid", line_valid, 1);
            check("stall_line_data", line_data, exp_line);
            check("stall_line_address", line_address, base);
            check("stall_fill_ready", fill_ready, 0);
        end
        line_ready = 1'b1;
        step();
        line_ready = 1'b0;
        check("post_fill_ready", fill_ready, 1);
        check("post_line_valid", line_valid, 0);
        check("post_line_hold", line_data, exp_line);
    endtask

    initial begin
        logic [CW-1:0] saved_line;
        logic [31:0]   saved_req;
        reset        = 1'b1;
        fill_valid   = 1'b0;
        fill_address = '0;
        line_ready   = 1'b0;
        req_ready    = 1'b0;
        dp_valid     = 1'b0;
        dp_read_data = '0;
        #12;
        check_reset_outputs("rst");
        reset = 1'b0;
        step();

        key = '0;
        run_fill(32'h0000_1000, 0, 0, 0, 0, 0, 0);
        run_fill(32'h0000_100A, 0, 0, 0, 0, 0, 0);
        run_fill(32'h0000_1004, 3, 5, 0, 0, 0, 0);
        run_fill(32'h0000_1010, 0, 0, 4, 0, 0, 1);
        run_fill(32'h0000_1020, 1, 0, 0, 0, 0, 0);

        saved_line = line_data;
        saved_req  = req_address;
        for (int i = 0; i < 3; i++) begin
            dp_valid     = 1'b1;
            dp_read_data = $urandom;
            step();
            check("idle_stray_line", line_data, saved_line);
            check("idle_stray_idx", req_address, saved_req);
        end
        dp_valid = 1'b0;
        run_fill(32'h0000_1034, 2, 1, 0, 1, 0, 0);

        run_fill(32'h0000_3008, 0, 0, 0, 0, 2, 0);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("no_req_after_rst", req_valid, 0);
        end
        run_fill(32'h0000_2004, 0, 0, 0, 0, 0, 0);

        for (int r = 0; r < 10; r++) begin
            key = $urandom;
            run_fill($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
